sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the single external SRAM port (18-bit address, 16-bit data, active-low write enable) between the decoder's requesters: the VGA frame fetcher, the Milestone 1 upsample/colour-space converter and the Milestone 2 IDCT. It sits between those requesters and the SRAM controller. It grants bounded-length bursts in round-robin order, drives the registered SRAM address, data and write-enable outputs, and routes read data back to the issuing requester.

## Interface
- NUM_REQ, 3: number of requesters; index 0 is the VGA fetcher.
- ADDR_W, 18: SRAM address width.
- DATA_W, 16: SRAM data width.
- MAX_BURST, 8: maximum accepted accesses per grant before forced re-arbitration; must be ≥1.
- READ_LATENCY, 2: cycles from SRAM_address driven to SRAM_read_data valid.
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester access request; held with its command until gnt.
- req_we_n  in  NUM_REQ  per-requester access type: 0 = write, 1 = read.
- req_addr  in  NUM_REQ×ADDR_W  per-requester address.
- req_wdata  in  NUM_REQ×DATA_W  per-requester write data.
- gnt  out  NUM_REQ  combinational; accepts the command this cycle (one-hot or zero).
- rvalid  out  NUM_REQ  one-hot read-return strobe.
- rdata  out  DATA_W  shared read data; qualified by rvalid.
- SRAM_address  out  ADDR_W  registered SRAM address.
- SRAM_write_data  out  DATA_W  registered SRAM write data.
- SRAM_we_n  out  1  registered write enable, active low.
- SRAM_read_data  in  DATA_W  SRAM read data.

## Operation
- FSM states:
  - S_ARB_IDLE: no owner; gnt = 0.
  - S_ARB_BURST: owner register holds the granted requester.
- IDLE → BURST: when any req is high. Owner = first requester with req set, searching circularly from rr_ptr. Transition takes one cycle; no gnt is issued in the IDLE cycle.
- In BURST:
  - gnt[owner] = req[owner].
  - Each accepted access (req & gnt) increments burst_cnt.
  - SRAM outputs load the owner's command on the next edge.
- BURST → IDLE when either:
  - req[owner] is low, or
  - an access is accepted with burst_cnt == MAX_BURST−1.
- On leaving BURST: rr_ptr ← owner+1 modulo NUM_REQ (wraps NUM_REQ−1 → 0); burst_cnt ← 0.
- Cycles with no accepted access: SRAM_we_n = 1; SRAM_address and SRAM_write_data hold their last value.
- Read return:
  - Each accepted read pushes {valid, id} into a tag shift register.
  - The tag emerges READ_LATENCY+1 cycles later and asserts rvalid[id].
  - rdata = SRAM_read_data, passed through.
  - Writes push valid = 0.
- Owner switches do not flush in-flight reads. Tags stay ordered because SRAM access is in order.
- Simultaneous requests: only the round-robin winner is granted; the others wait with req held.
- A requester dropping req while not owner: no effect.

## Timing
- Reset values: SRAM_address = 0, SRAM_write_data = 0, SRAM_we_n = 1, gnt = 0, rvalid = 0, state = S_ARB_IDLE, rr_ptr = 0, burst_cnt = 0, tag pipe all invalid.
- Reset mid-burst: in-flight reads are discarded and no rvalid fires for them.
- Access accepted in cycle t → SRAM_address/we_n valid in cycle t+1 → rvalid/rdata in cycle t+1+READ_LATENCY.
- Throughput: one access per cycle within a burst. One idle cycle per re-arbitration.
- Worst-case wait for a requester: (NUM_REQ−1)×(MAX_BURST+1) cycles.

## Configuration
- SRAM_ARB_VGA_PRIORITY_EN defined:
  - In S_ARB_IDLE, req[0] always wins regardless of rr_ptr.
  - A BURST owned by another requester ends after its current accepted access whenever req[0] is high.
  - rr_ptr advances only among requesters 1..NUM_REQ−1.
- Not defined: pure round-robin for all requesters, as in Operation.

## Structure
- Shared package sram_arb_pkg:
  - arb_state_t enum (S_ARB_IDLE, S_ARB_BURST).
  - REQ_VGA / REQ_M1 / REQ_M2 index constants.
  - Tag struct {valid, id}.
  - Default READ_LATENCY.
- One sub-module: sram_arb_rr_pick, a combinational circular priority picker (req vector, rr_ptr → one-hot winner, any).

## Test plan
- Reset → SRAM_we_n = 1, gnt = 0, rvalid = 0. Assert Reset mid-burst with 2 reads in flight → no rvalid afterwards.
- Only req[1] holds reads to addresses 38400..38411 → bursts of 8 then 4 accesses with one idle cycle between. rvalid[1] is high 3 cycles after each gnt, with rdata = SRAM model value.
- req[0..2] all held → grant order 0, 1, 2, 0 with 8 accesses each and one bubble per switch. rr_ptr wraps 2 → 0.
- req[2] write 0xABCD to 146944 → SRAM_we_n low for exactly one cycle, in the cycle after gnt, with SRAM_address = 146944. No rvalid fires.
- Requester 1 reads 0, then requester 2 reads 57600 back-to-back across a switch → rvalid[1] precedes rvalid[2]. Each rdata matches its own address.
- With SRAM_ARB_VGA_PRIORITY_EN: req[1] bursting, req[0] rises mid-burst → requester 1's burst ends after its current access; requester 0 is granted 2 cycles later.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// Provides FSM state enum, requester indices, read-tag struct, defaults.
package sram_arb_pkg;

   typedef enum logic {
      S_ARB_IDLE,
      S_ARB_BURST
   } arb_state_t;

   localparam int REQ_VGA = 0;
   localparam int REQ_M1  = 1;
   localparam int REQ_M2  = 2;

   localparam int DEF_NUM_REQ      = 3;
   localparam int DEF_READ_LATENCY = 2;
   localparam int TAG_ID_W         = 2;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } arb_tag_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational circular priority picker: first set req from ptr upward.
// Ports: req_i (requests), ptr_i (start index), win_o (one-hot), any_o.
module sram_arb_rr_pick #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  win_o,
   output logic          any_o
);

   logic [PW-1:0] idx;

   always_comb begin
      win_o = '0;
      any_o = 1'b0;
      idx   = ptr_i;
      for (int k = 0; k < N; k++) begin
         if (!any_o && req_i[idx]) begin
            win_o[idx] = 1'b1;
            any_o      = 1'b1;
         end
         idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin burst arbiter sharing one SRAM port among requesters.
// Ports: clk_i, rst_i (async high); req_*_i per-requester command;
// gnt_o (comb), rvalid_o/rdata_o read return; SRAM_*_o registered port;
// SRAM_read_data_i. Define SRAM_ARB_VGA_PRIORITY_EN to give requester 0
// absolute priority over the round-robin.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_REQ      = DEF_NUM_REQ,
   parameter int ADDR_W       = 18,
   parameter int DATA_W       = 16,
   parameter int MAX_BURST    = 8,
   parameter int READ_LATENCY = DEF_READ_LATENCY
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ-1:0]              req_i,
   input  logic [NUM_REQ-1:0]              req_we_n_i,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   output logic [NUM_REQ-1:0]              rvalid_o,
   output logic [DATA_W-1:0]               rdata_o,
   output logic [ADDR_W-1:0]               SRAM_address_o,
   output logic [DATA_W-1:0]               SRAM_write_data_o,
   output logic                            SRAM_we_n_o,
   input  logic [DATA_W-1:0]               SRAM_read_data_i
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

   arb_state_t    state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] rr_q, rr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic              we_n_q, we_n_d;
   arb_tag_t          tag_q [READ_LATENCY+1];
   arb_tag_t          push;

   logic [NUM_REQ-1:0] pick_req;
   logic [NUM_REQ-1:0] win;
   logic               win_any;
   logic [PW-1:0]      win_idx;
   logic               acc;
   logic               leave;

`ifdef SRAM_ARB_VGA_PRIORITY_EN
   // VGA is handled outside the rotation, so mask it from the picker.
   assign pick_req = req_i & ~(NUM_REQ'(1) << REQ_VGA);
`else
   assign pick_req = req_i;
`endif

   sram_arb_rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req_i (pick_req),
      .ptr_i (rr_q),
      .win_o (win),
      .any_o (win_any)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win[i]) win_idx = PW'(i);
      end
   end

   function automatic logic [PW-1:0] next_ptr(
      input logic [PW-1:0] own,
      input logic [PW-1:0] cur
   );
`ifdef SRAM_ARB_VGA_PRIORITY_EN
      if (own == PW'(REQ_VGA)) return cur;
      return (own == PW'(NUM_REQ - 1)) ? PW'(1) : own + 1'b1;
`else
      if (cur == own) begin end
      return (own == PW'(NUM_REQ - 1)) ? '0 : own + 1'b1;
`endif
   endfunction

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      gnt_o   = '0;
      acc     = 1'b0;
      leave   = 1'b0;
      unique case (state_q)
         S_ARB_IDLE: begin
            if (|req_i) begin
               state_d = S_ARB_BURST;
               owner_d = win_idx;
`ifdef SRAM_ARB_VGA_PRIORITY_EN
               if (req_i[REQ_VGA] || !win_any)
                  owner_d = PW'(REQ_VGA);
`endif
            end
         end
         S_ARB_BURST: begin
            gnt_o[owner_q] = req_i[owner_q];
            acc = req_i[owner_q];
            if (!acc) begin
               leave = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) leave = 1'b1;
`ifdef SRAM_ARB_VGA_PRIORITY_EN
               if (req_i[REQ_VGA] && owner_q != PW'(REQ_VGA))
                  leave = 1'b1;
`endif
            end
            if (leave) begin
               state_d = S_ARB_IDLE;
               cnt_d   = '0;
               rr_d    = next_ptr(owner_q, rr_q);
            end
         end
         default: state_d = S_ARB_IDLE;
      endcase
   end

   always_comb begin
      addr_d = addr_q;
      wd_d   = wd_q;
      we_n_d = 1'b1;
      if (acc) begin
         addr_d = req_addr_i[owner_q];
         wd_d   = req_wdata_i[owner_q];
         we_n_d = req_we_n_i[owner_q];
      end
      push.valid = acc & req_we_n_i[owner_q];
      push.id    = TAG_ID_W'(owner_q);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_ARB_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wd_q    <= '0;
         we_n_q  <= 1'b1;
         for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wd_q    <= wd_d;
         we_n_q  <= we_n_d;
         tag_q[0] <= push;
         for (int i = 1; i <= READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Last tag stage lines up with SRAM_read_data for that access.
   always_comb begin
      rvalid_o = '0;
      if (tag_q[READ_LATENCY].valid) rvalid_o[tag_q[READ_LATENCY].id] = 1'b1;
   end

   assign rdata_o           = SRAM_read_data_i;
   assign SRAM_address_o    = addr_q;
   assign SRAM_write_data_o = wd_q;
   assign SRAM_we_n_o       = we_n_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter.
// Drives per-requester command streams and checks grants and SRAM port.
module tb_sram_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]         req = '0;
  logic [N-1:0]         req_we_n = '1;
  logic [N-1:0][AW-1:0] req_addr = '0;
  logic [N-1:0][DW-1:0] req_wdata = '0;
  logic [N-1:0]         gnt, rvalid;
  logic [DW-1:0]        rdata, sram_wd, sram_rd;
  logic [AW-1:0]        sram_addr;
  logic                 sram_we_n;

  sram_port_arbiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .req_i             (req),
    .req_we_n_i        (req_we_n),
    .req_addr_i        (req_addr),
    .req_wdata_i       (req_wdata),
    .gnt_o             (gnt),
    .rvalid_o          (rvalid),
    .rdata_o           (rdata),
    .SRAM_address_o    (sram_addr),
    .SRAM_write_data_o (sram_wd),
    .SRAM_we_n_o       (sram_we_n),
    .SRAM_read_data_i  (sram_rd)
  );

  function automatic logic [DW-1:0] mem(
    input logic [AW-1:0] a
  );
    return a[15:0] ^ 16'h5A5A;
  endfunction

  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    a1 <= sram_addr;
    a2 <= a1;
  end
  assign sram_rd = mem(a2);

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int rem [N];
  int rv_cyc [N];

  logic [N-1:0]  e_rv  [8];
  logic [DW-1:0] e_rd  [8];
  logic          e_acc [8];
  logic          e_we  [8];
  logic [AW-1:0] e_ad  [8];
  logic [DW-1:0] e_wd  [8];
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wd;

  task automatic chk(
    input string       tag,
    input logic [31:0] o,
    input logic [31:0] e
  );
    n_chk++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
             tag, o, e, cyc);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 8; k++) begin
      e_rv[k]  = '0;
      e_acc[k] = 1'b0;
    end
    hold_addr = '0;
    hold_wd   = '0;
  endtask

  task automatic step(input logic [N-1:0] exp_gnt);
    int s;
    logic [N-1:0] g;
    logic         exp_we;
    @(negedge clk);
    s = cyc % 8;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("rvalid", 32'(rvalid), 32'(e_rv[s]));
    if (e_rv[s] != '0)
      chk("rdata", 32'(rdata), 32'(e_rd[s]));
    for (int i = 0; i < N; i++)
      if (rvalid[i]) rv_cyc[i] = cyc;
    exp_we = 1'b1;
    if (e_acc[s]) begin
      hold_addr = e_ad[s];
      hold_wd   = e_wd[s];
      exp_we    = e_we[s];
    end
    chk("we_n", 32'(sram_we_n), 32'(exp_we));
    chk("addr", 32'(sram_addr), 32'(hold_addr));
    chk("wdata", 32'(sram_wd), 32'(hold_wd));
    e_rv[s]  = '0;
    e_acc[s] = 1'b0;
    g = gnt;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        e_acc[(cyc+1)%8] = 1'b1;
        e_ad[(cyc+1)%8]  = req_addr[i];
        e_we[(cyc+1)%8]  = req_we_n[i];
        e_wd[(cyc+1)%8]  = req_wdata[i];
        if (req_we_n[i]) begin
          e_rv[(cyc+3)%8] = 3'b001 << i;
          e_rd[(cyc+3)%8] = mem(req_addr[i]);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        rem[i]--;
        req_addr[i] = req_addr[i] + 1'b1;
      end
      req[i] = (rem[i] > 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    clr();
    step(3'b000);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      rv_cyc[i] = -1;
    end
    clr();
    do_reset();

    req_addr[1] = 18'd38400;
    rem[1] = 12;
    req = 3'b010;
    step(3'b000);
    repeat (8) step(3'b010);
    step(3'b000);
    repeat (4) step(3'b010);
    repeat (4) step(3'b000);

`ifndef SRAM_ARB_VGA_PRIORITY_EN
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_addr[i] = AW'(i * 1000);
      rem[i] = 16;
    end
    req = 3'b111;
    step(3'b000);
    for (int p = 0; p < 6; p++) begin
      repeat (8) step(3'b001 << (p % 3));
      step(3'b000);
    end
    repeat (3) step(3'b000);

    req_we_n[2]  = 1'b0;
    req_addr[2]  = 18'd146944;
    req_wdata[2] = 16'hABCD;
    rem[2] = 1;
    req = 3'b100;
    step(3'b000);
    step(3'b100);
    repeat (4) step(3'b000);
    req_we_n[2] = 1'b1;

    for (int i = 0; i < N; i++) rv_cyc[i] = -1;
    req_addr[1] = 18'd0;
    req_addr[2] = 18'd57600;
    rem[1] = 1;
    rem[2] = 1;
    req = 3'b110;
    step(3'b000);
    step(3'b010);
    step(3'b000);
    step(3'b000);
    step(3'b100);
    repeat (4) step(3'b000);
    chk("rv1_seen", 32'(rv_cyc[1] >= 0), 32'd1);
    chk("rv_order", 32'(rv_cyc[1] < rv_cyc[2]), 32'd1);
`else
    do_reset();
    req_addr[1] = 18'd200;
    rem[1] = 16;
    req = 3'b010;
    step(3'b000);
    repeat (3) step(3'b010);
    req_addr[0] = 18'd300;
    rem[0] = 2;
    req[0] = 1'b1;
    step(3'b010);
    step(3'b000);
    step(3'b001);
    step(3'b001);
    step(3'b000);
    step(3'b000);
    step(3'b010);
`endif

    do_reset();
    req_addr[1] = 18'd100;
    rem[1] = 8;
    req = 3'b010;
    step(3'b000);
    step(3'b010);
    step(3'b010);
    rst = 1'b1;
    req = '0;
    rem[1] = 0;
    clr();
    repeat (2) step(3'b000);
    rst = 1'b0;
    repeat (4) step(3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
